// File: rtl/lzd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzd_pkg
// Brief    : Shared constants and helpers for the pipelined leading-bit counter.
// Revision : 1.0
// ============================================================================
package lzd_pkg;

    localparam logic LZD_MODE_LZ = 1'b0;
    localparam logic LZD_MODE_LO = 1'b1;

    function automatic int lzd_cw(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzd_group_scan.sv
`default_nettype none
// ============================================================================
// Module   : lzd_group_scan
// Brief    : One GROUP-bit slice: all-zero flag and in-group leading-zero count.
// Revision : 1.0
// ============================================================================
module lzd_group_scan #(
    parameter  int GROUP = 4,
    localparam int GW    = $clog2(GROUP)
) (
    input  logic [GROUP-1:0] grp_i,
    output logic             zero_o,
    output logic [GW-1:0]    lz_o
);

    // Scanning upward lets the most significant set bit win; lz_o is
    // don't-care when the group is all zero.
    always_comb begin
        zero_o = ~|grp_i;
        lz_o   = '0;
        for (int i = 0; i < GROUP; i++) begin
            if (grp_i[i]) begin
                lz_o = GW'(GROUP - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lzd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzd_pipe
// Brief    : Two-stage pipelined leading-zero / leading-one counter with
//            valid/ready handshakes, tag pass-through and synchronous flush.
//            Optional normalising shifter enabled by LZD_PIPE_SHIFT_EN.
// Revision : 1.0
// ============================================================================
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int GROUP = 4,
    parameter  int TAG_W = 4,
    localparam int CW    = lzd_cw(XLEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  data_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    count_o,
    output logic             all_o,
    output logic [TAG_W-1:0] tag_o
`ifdef LZD_PIPE_SHIFT_EN
    ,
    output logic [XLEN-1:0]  norm_o
`endif
);

    localparam int NG = XLEN / GROUP;
    localparam int GW = $clog2(GROUP);

    generate
        if ((XLEN % GROUP) != 0 || GROUP < 2 || GROUP > 16 || (GROUP & (GROUP - 1)) != 0) begin : g_bad_cfg
            $error("lzd_pipe: XLEN must be a multiple of GROUP, GROUP a power of two in 2..16");
        end
    endgenerate

    // ---------------- entry and per-group scan ----------------
    logic [XLEN-1:0]        data_inv;
    logic [NG-1:0]          gz_scan;
    logic [NG-1:0][GW-1:0]  lz_scan;

    assign data_inv = (mode_i == LZD_MODE_LO) ? ~data_i : data_i;

    // Group 0 sits at the most significant end of the operand.
    generate
        for (genvar k = 0; k < NG; k++) begin : g_scan
            lzd_group_scan #(.GROUP(GROUP)) u_scan (
                .grp_i  (data_inv[XLEN-1-k*GROUP -: GROUP]),
                .zero_o (gz_scan[k]),
                .lz_o   (lz_scan[k])
            );
        end
    endgenerate

    // ---------------- state ----------------
    logic                   s1_valid_q, s1_valid_d;
    logic [NG-1:0]          gz_q, gz_d;
    logic [NG-1:0][GW-1:0]  lz_q, lz_d;
    logic [TAG_W-1:0]       tag1_q, tag1_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   all_q, all_d;
    logic [TAG_W-1:0]       tag2_q, tag2_d;
`ifdef LZD_PIPE_SHIFT_EN
    logic [XLEN-1:0]        data1_q, data1_d;
    logic                   mode1_q, mode1_d;
    logic [XLEN-1:0]        norm_q, norm_d;
    logic [XLEN-1:0]        orig_s1;
    logic [XLEN-1:0]        norm_c;
`endif

    logic          s2_load;
    logic          accept;
    logic [CW-1:0] count_c;
    logic          all_c;

    // ---------------- handshake ----------------
    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready_i);
        in_ready_o = !s1_valid_q || !s2_valid_q || out_ready_i;
        accept     = in_valid_i && in_ready_o;

        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready_i) begin
            s2_valid_d = 1'b0;
        end

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // ---------------- stage 2 priority encode ----------------
    always_comb begin
        all_c   = &gz_q;
        count_c = CW'(XLEN);
        for (int k = NG - 1; k >= 0; k--) begin
            if (!gz_q[k]) begin
                count_c = CW'(k * GROUP) + CW'(lz_q[k]);
            end
        end
    end

`ifdef LZD_PIPE_SHIFT_EN
    // Shift the operand as presented, not the inverted copy held in stage 1.
    always_comb begin
        orig_s1 = (mode1_q == LZD_MODE_LO) ? ~data1_q : data1_q;
        norm_c  = all_c ? '0 : (orig_s1 << count_c);
    end
`endif

    // ---------------- next-state for data registers ----------------
    always_comb begin
        gz_d    = gz_q;
        lz_d    = lz_q;
        tag1_d  = tag1_q;
        count_d = count_q;
        all_d   = all_q;
        tag2_d  = tag2_q;
`ifdef LZD_PIPE_SHIFT_EN
        data1_d = data1_q;
        mode1_d = mode1_q;
        norm_d  = norm_q;
`endif
        if (accept && !flush_i) begin
            gz_d    = gz_scan;
            lz_d    = lz_scan;
            tag1_d  = tag_i;
`ifdef LZD_PIPE_SHIFT_EN
            data1_d = data_inv;
            mode1_d = mode_i;
`endif
        end
        if (s2_load && !flush_i) begin
            count_d = count_c;
            all_d   = all_c;
            tag2_d  = tag1_q;
`ifdef LZD_PIPE_SHIFT_EN
            norm_d  = norm_c;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            gz_q       <= '0;
            lz_q       <= '0;
            tag1_q     <= '0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
            all_q      <= 1'b0;
            tag2_q     <= '0;
`ifdef LZD_PIPE_SHIFT_EN
            data1_q    <= '0;
            mode1_q    <= 1'b0;
            norm_q     <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            gz_q       <= gz_d;
            lz_q       <= lz_d;
            tag1_q     <= tag1_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
            all_q      <= all_d;
            tag2_q     <= tag2_d;
`ifdef LZD_PIPE_SHIFT_EN
            data1_q    <= data1_d;
            mode1_q    <= mode1_d;
            norm_q     <= norm_d;
`endif
        end
    end

    assign out_valid_o = s2_valid_q;
    assign count_o     = count_q;
    assign all_o       = all_q;
    assign tag_o       = tag2_q;
`ifdef LZD_PIPE_SHIFT_EN
    assign norm_o      = norm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzd_pipe
// Brief    : Directed, table-driven bench for lzd_pipe (XLEN=16, GROUP=4).
// Revision : 1.0
// ============================================================================
module tb_lzd_pipe;

    localparam int XLEN  = 16;
    localparam int GROUP = 4;
    localparam int TAG_W = 4;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  data;
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             all_bits;
    logic [TAG_W-1:0] tag_out;
`ifdef LZD_PIPE_SHIFT_EN
    logic [XLEN-1:0]  norm;
`endif

    lzd_pipe #(.XLEN(XLEN), .GROUP(GROUP), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data),
        .mode_i      (mode),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count),
        .all_o       (all_bits),
        .tag_o       (tag_out)
`ifdef LZD_PIPE_SHIFT_EN
        ,
        .norm_o      (norm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic             mode;
        logic [TAG_W-1:0] tag;
        logic [CW-1:0]    exp_count;
        logic             exp_all;
        logic [XLEN-1:0]  exp_norm;
    } vec_t;

    vec_t vecs [11];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_vec(input vec_t v, input int idx);
        data      = v.data;
        mode      = v.mode;
        tag       = v.tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_count", idx), 32'(count), 32'(v.exp_count));
        check($sformatf("v%0d_all", idx), 32'(all_bits), 32'(v.exp_all));
        check($sformatf("v%0d_tag", idx), 32'(tag_out), 32'(v.tag));
`ifdef LZD_PIPE_SHIFT_EN
        check($sformatf("v%0d_norm", idx), 32'(norm), 32'(v.exp_norm));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int got;
        int seen;
        logic acc;

        //            data      mode  tag   count  all   norm
        vecs[0]  = '{16'h0F00, 1'b0, 4'h3, 5'd4,  1'b0, 16'hF000};
        vecs[1]  = '{16'h0000, 1'b0, 4'h1, 5'd16, 1'b1, 16'h0000};
        vecs[2]  = '{16'hFFFF, 1'b1, 4'h2, 5'd16, 1'b1, 16'h0000};
        vecs[3]  = '{16'hF0FF, 1'b1, 4'h4, 5'd4,  1'b0, 16'h0FF0};
        vecs[4]  = '{16'h0001, 1'b0, 4'h5, 5'd15, 1'b0, 16'h8000};
        vecs[5]  = '{16'h8000, 1'b0, 4'h6, 5'd0,  1'b0, 16'h8000};
        vecs[6]  = '{16'h0000, 1'b1, 4'h7, 5'd0,  1'b0, 16'h0000};
        vecs[7]  = '{16'h00F0, 1'b0, 4'h8, 5'd8,  1'b0, 16'hF000};
        vecs[8]  = '{16'h7FFF, 1'b1, 4'h9, 5'd0,  1'b0, 16'h7FFF};
        vecs[9]  = '{16'hFFFE, 1'b1, 4'hA, 5'd15, 1'b0, 16'h0000};
        vecs[10] = '{16'h0300, 1'b0, 4'hF, 5'd6,  1'b0, 16'hC000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data = '0; mode = 1'b0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_all", 32'(all_bits), 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LZD_PIPE_SHIFT_EN
        check("rst_norm", 32'(norm), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            send_vec(vecs[i], i);
        end

        // drain the last result
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", 32'(out_valid), 32'd0);

        // backpressure: tags 1..4, consumer stalled for the first 4 cycles
        nxt = 1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (nxt <= 4);
            data      = 16'(16'h8000 >> nxt);
            mode      = 1'b0;
            tag       = TAG_W'(nxt);
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                check($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
                check($sformatf("bp_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                check($sformatf("bp_hold_tag_c%0d", cyc), 32'(tag_out), 32'd1);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got++;
                check($sformatf("bp_tag_%0d", got), 32'(tag_out), 32'(got));
                check($sformatf("bp_count_%0d", got), 32'(count), 32'(got));
            end
            @(posedge clk); #1;
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        check("bp_results", 32'(got), 32'd4);
        check("bp_accepts", 32'(nxt), 32'd5);
        @(posedge clk); #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // flush with both stages full and an accept offered the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data      = 16'h0F00;
        tag       = 4'h5;
        @(posedge clk); #1;
        tag = 4'h6;
        @(posedge clk); #1;
        check("fl_full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tag       = 4'h7;
        flush     = 1'b1;
        @(negedge clk);
        check("fl_offer_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid_next", 32'(out_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("fl_no_results", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
